// File: rtl/seg7_scan_if.sv
// Board-side bundle for the multiplexed 7-segment display driver.
// master = core/test side, slave = seg7_scan_driver.
interface seg7_scan_if #(
  parameter int NUM_DIGITS = 8
);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] data;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    blank_lz;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    slot_end;

  modport master (
    output load, data, dp_in, blank_lz,
    input  seg, dp, an, slot_end
  );

  modport slave (
    input  load, data, dp_in, blank_lz,
    output seg, dp, an, slot_end
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex display driver: shadow latch, slot scan,
// anti-ghost blanking, leading-zero suppression, output polarity.
module seg7_scan_driver #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_CYC  = 500,
  parameter int ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        reset,
  seg7_scan_if.slave  bus
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);
  localparam logic POL = (ACTIVE_LOW != 0);

  logic [4*NUM_DIGITS-1:0] shadow;
  logic [NUM_DIGITS-1:0]   dp_sh;
  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;

  logic                  in_blank;
  logic                  upper_nz;
  logic                  lz_hide;
  logic [3:0]            nib;
  logic [6:0]            seg_d;
  logic                  dp_d;
  logic [NUM_DIGITS-1:0] an_d;

  logic [6:0]            seg_q;
  logic                  dp_q;
  logic [NUM_DIGITS-1:0] an_q;

  function automatic logic [6:0] font(input logic [3:0] n);
    logic [6:0] f;
    unique case (n)
      4'h0: f = 7'h3F;
      4'h1: f = 7'h06;
      4'h2: f = 7'h5B;
      4'h3: f = 7'h4F;
      4'h4: f = 7'h66;
      4'h5: f = 7'h6D;
      4'h6: f = 7'h7D;
      4'h7: f = 7'h07;
      4'h8: f = 7'h7F;
      4'h9: f = 7'h6F;
      4'hA: f = 7'h77;
      4'hB: f = 7'h7C;
      4'hC: f = 7'h39;
      4'hD: f = 7'h5E;
      4'hE: f = 7'h79;
      4'hF: f = 7'h71;
    endcase
    return f;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow <= '0;
      dp_sh  <= '0;
    end else if (bus.load) begin
      shadow <= bus.data;
      dp_sh  <= bus.dp_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
      idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // A digit is suppressed when it and every nibble above it are zero.
  always_comb begin
    in_blank = (int'(cnt) < BLANK_CYC);
    nib      = shadow[{idx, 2'b00} +: 4];
    upper_nz = 1'b0;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if ((j >= int'(idx)) && (shadow[4*j +: 4] != 4'h0))
        upper_nz = 1'b1;
    end
    lz_hide = bus.blank_lz && (idx != '0) && !upper_nz;
    an_d    = '0;
    seg_d   = '0;
    dp_d    = 1'b0;
    if (!in_blank) begin
      an_d  = NUM_DIGITS'(1) << idx;
      seg_d = lz_hide ? 7'h00 : font(nib);
      dp_d  = dp_sh[idx];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_q <= {7{POL}};
      dp_q  <= POL;
      an_q  <= {NUM_DIGITS{POL}};
    end else begin
      seg_q <= seg_d ^ {7{POL}};
      dp_q  <= dp_d ^ POL;
      an_q  <= an_d ^ {NUM_DIGITS{POL}};
    end
  end

  assign bus.seg      = seg_q;
  assign bus.dp       = dp_q;
  assign bus.an       = an_q;
  assign bus.slot_end = (cnt == CNT_MAX);

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: NUM_DIGITS=4, SCAN_DIV=4,
// BLANK_CYC=1; one instance per output polarity.
module tb_seg7_scan_driver;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seg7_scan_if #(.NUM_DIGITS(4)) b0 ();
  seg7_scan_if #(.NUM_DIGITS(4)) b1 ();

  assign b1.load     = b0.load;
  assign b1.data     = b0.data;
  assign b1.dp_in    = b0.dp_in;
  assign b1.blank_lz = b0.blank_lz;

  seg7_scan_driver #(
    .NUM_DIGITS(4), .SCAN_DIV(4),
    .BLANK_CYC(1), .ACTIVE_LOW(0)
  ) u0 (
    .clk(clk), .reset(reset), .bus(b0)
  );

  seg7_scan_driver #(
    .NUM_DIGITS(4), .SCAN_DIV(4),
    .BLANK_CYC(1), .ACTIVE_LOW(1)
  ) u1 (
    .clk(clk), .reset(reset), .bus(b1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset, preset inputs with load high, release; the next edge is edge 1.
  task automatic do_reset(input logic [15:0] d,
                          input logic [3:0] p,
                          input logic blz);
    @(posedge clk);
    #1;
    reset = 1'b1;
    b0.load = 1'b1;
    b0.data = d;
    b0.dp_in = p;
    b0.blank_lz = blz;
    #3;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    b0.load = 1'b0;
    b0.data = 16'h0;
    b0.dp_in = 4'h0;
    b0.blank_lz = 1'b0;
    #2;
    checks++;
    if (b0.an !== 4'h0) begin
      errors++; $display("FAIL rst_an got %h exp 0", b0.an);
    end
    checks++;
    if (b0.seg !== 7'h00) begin
      errors++; $display("FAIL rst_seg got %h exp 00", b0.seg);
    end
    checks++;
    if (b0.dp !== 1'b0) begin
      errors++; $display("FAIL rst_dp got %b exp 0", b0.dp);
    end
    checks++;
    if (b0.slot_end !== 1'b0) begin
      errors++; $display("FAIL rst_slot_end got %b exp 0", b0.slot_end);
    end
    checks++;
    if (b1.an !== 4'hF) begin
      errors++; $display("FAIL rst_an_al got %h exp F", b1.an);
    end
    checks++;
    if (b1.seg !== 7'h7F) begin
      errors++; $display("FAIL rst_seg_al got %h exp 7F", b1.seg);
    end
    checks++;
    if (b1.dp !== 1'b1) begin
      errors++; $display("FAIL rst_dp_al got %b exp 1", b1.dp);
    end
  endtask

  task automatic test_scan();
    logic [3:0] an_t [16];
    logic [6:0] seg_t [16];
    logic       se_t [16];
    an_t  = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h2,
              4'h0, 4'h4, 4'h4, 4'h4, 4'h0, 4'h8, 4'h8, 4'h8};
    seg_t = '{7'h00, 7'h3F, 7'h3F, 7'h3F, 7'h00, 7'h7F, 7'h7F, 7'h7F,
              7'h00, 7'h77, 7'h77, 7'h77, 7'h00, 7'h06, 7'h06, 7'h06};
    se_t  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
              1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    do_reset(16'h1A80, 4'h0, 1'b0);
    for (int e = 0; e < 16; e++) begin
      tick();
      b0.load = 1'b0;
      checks++;
      if (b0.an !== an_t[e]) begin
        errors++;
        $display("FAIL scan_an edge %0d got %h exp %h", e + 1, b0.an, an_t[e]);
      end
      checks++;
      if (b0.seg !== seg_t[e]) begin
        errors++;
        $display("FAIL scan_seg edge %0d got %h exp %h", e + 1, b0.seg, seg_t[e]);
      end
      checks++;
      if (b0.slot_end !== se_t[e]) begin
        errors++;
        $display("FAIL scan_slot_end edge %0d got %b exp %b",
                 e + 1, b0.slot_end, se_t[e]);
      end
    end
  endtask

  task automatic test_lz();
    logic [6:0] s50 [4];
    logic [6:0] s00 [4];
    s50 = '{7'h3F, 7'h6D, 7'h00, 7'h00};
    s00 = '{7'h3F, 7'h00, 7'h00, 7'h00};
    for (int v = 0; v < 2; v++) begin
      do_reset((v == 0) ? 16'h0050 : 16'h0000, 4'h0, 1'b1);
      tick();
      b0.load = 1'b0;
      for (int d = 0; d < 4; d++) begin
        tick();
        checks++;
        if (b0.an !== (4'h1 << d)) begin
          errors++;
          $display("FAIL lz_an v%0d digit %0d got %h exp %h",
                   v, d, b0.an, 4'h1 << d);
        end
        checks++;
        if (b0.seg !== ((v == 0) ? s50[d] : s00[d])) begin
          errors++;
          $display("FAIL lz_seg v%0d digit %0d got %h exp %h", v, d,
                   b0.seg, (v == 0) ? s50[d] : s00[d]);
        end
        tick(); tick(); tick();
      end
    end
    b0.blank_lz = 1'b0;
  endtask

  task automatic test_dp();
    do_reset(16'h1234, 4'b0100, 1'b0);
    for (int e = 1; e <= 16; e++) begin
      tick();
      b0.load = 1'b0;
      checks++;
      if (b0.dp !== (e >= 10 && e <= 12)) begin
        errors++;
        $display("FAIL dp edge %0d got %b exp %b", e, b0.dp, e >= 10 && e <= 12);
      end
    end
  endtask

  task automatic test_active_low();
    do_reset(16'h0008, 4'h0, 1'b0);
    tick();
    b0.load = 1'b0;
    checks++;
    if (b1.an !== 4'hF || b1.seg !== 7'h7F || b1.dp !== 1'b1) begin
      errors++;
      $display("FAIL al_blank1 got an=%h seg=%h dp=%b exp F 7F 1",
               b1.an, b1.seg, b1.dp);
    end
    tick();
    checks++;
    if (b1.an !== 4'hE || b1.seg !== 7'h00 || b1.dp !== 1'b1) begin
      errors++;
      $display("FAIL al_digit0 got an=%h seg=%h dp=%b exp E 00 1",
               b1.an, b1.seg, b1.dp);
    end
    tick(); tick(); tick();
    checks++;
    if (b1.an !== 4'hF || b1.seg !== 7'h7F) begin
      errors++;
      $display("FAIL al_blank5 got an=%h seg=%h exp F 7F", b1.an, b1.seg);
    end
  endtask

  task automatic test_midslot_load();
    do_reset(16'h1111, 4'h0, 1'b0);
    tick();
    b0.load = 1'b0;
    for (int e = 2; e <= 6; e++) tick();
    checks++;
    if (b0.an !== 4'h2 || b0.seg !== 7'h06) begin
      errors++;
      $display("FAIL mid_e6 got an=%h seg=%h exp 2 06", b0.an, b0.seg);
    end
    b0.data = 16'h2222;
    b0.load = 1'b1;
    tick();
    b0.load = 1'b0;
    checks++;
    if (b0.seg !== 7'h06 || b0.slot_end !== 1'b1) begin
      errors++;
      $display("FAIL mid_e7 got seg=%h slot_end=%b exp 06 1",
               b0.seg, b0.slot_end);
    end
    tick();
    checks++;
    if (b0.an !== 4'h2 || b0.seg !== 7'h5B || b0.slot_end !== 1'b0) begin
      errors++;
      $display("FAIL mid_e8 got an=%h seg=%h slot_end=%b exp 2 5B 0",
               b0.an, b0.seg, b0.slot_end);
    end
    tick();
    checks++;
    if (b0.an !== 4'h0) begin
      errors++; $display("FAIL mid_e9 got an=%h exp 0", b0.an);
    end
    tick();
    checks++;
    if (b0.an !== 4'h4 || b0.seg !== 7'h5B) begin
      errors++;
      $display("FAIL mid_e10 got an=%h seg=%h exp 4 5B", b0.an, b0.seg);
    end
  endtask

  task automatic test_reset_midscan();
    do_reset(16'h1A80, 4'hF, 1'b0);
    tick();
    b0.load = 1'b0;
    for (int e = 2; e <= 10; e++) tick();
    checks++;
    if (b0.an !== 4'h4 || b0.seg !== 7'h77 || b0.dp !== 1'b1) begin
      errors++;
      $display("FAIL rm_pre got an=%h seg=%h dp=%b exp 4 77 1",
               b0.an, b0.seg, b0.dp);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (b0.an !== 4'h0 || b0.seg !== 7'h00 || b0.dp !== 1'b0) begin
      errors++;
      $display("FAIL rm_async got an=%h seg=%h dp=%b exp 0 00 0",
               b0.an, b0.seg, b0.dp);
    end
    checks++;
    if (b1.an !== 4'hF || b1.seg !== 7'h7F || b1.dp !== 1'b1) begin
      errors++;
      $display("FAIL rm_async_al got an=%h seg=%h dp=%b exp F 7F 1",
               b1.an, b1.seg, b1.dp);
    end
    #1;
    reset = 1'b0;
    tick();
    checks++;
    if (b0.an !== 4'h0) begin
      errors++; $display("FAIL rm_e1 got an=%h exp 0", b0.an);
    end
    tick();
    checks++;
    if (b0.an !== 4'h1 || b0.seg !== 7'h3F || b0.dp !== 1'b0) begin
      errors++;
      $display("FAIL rm_e2 got an=%h seg=%h dp=%b exp 1 3F 0",
               b0.an, b0.seg, b0.dp);
    end
    tick(); tick(); tick(); tick();
    checks++;
    if (b0.an !== 4'h2 || b0.seg !== 7'h3F) begin
      errors++;
      $display("FAIL rm_e6 got an=%h seg=%h exp 2 3F", b0.an, b0.seg);
    end
  endtask

  initial begin
    b0.load = 1'b0;
    b0.data = 16'h0;
    b0.dp_in = 4'h0;
    b0.blank_lz = 1'b0;
    reset = 1'b1;
    #12;
    reset = 1'b0;
    test_reset();
    test_scan();
    test_lz();
    test_dp();
    test_active_low();
    test_midslot_load();
    test_reset_midscan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
